// File: rtl/bp_be_pkg.sv
// Shared back-end definitions: stall-reason codes, reason count and the
// profiler drain-beat layout.
package bp_be_pkg;

  localparam int stall_reason_num_gp   = 24;
  localparam int stall_idx_width_gp    = $clog2(stall_reason_num_gp + 1);
  localparam int stall_count_width_gp  = 32;

  typedef enum logic [stall_idx_width_gp-1:0] {
    e_stall_unknown            = 5'd0,
    e_stall_icache_miss        = 5'd1,
    e_stall_itlb_miss          = 5'd2,
    e_stall_branch_mispredict  = 5'd3,
    e_stall_fe_queue_empty     = 5'd4,
    e_stall_dcache_miss        = 5'd5,
    e_stall_dtlb_miss          = 5'd6,
    e_stall_long_latency_int   = 5'd7,
    e_stall_fpu_busy           = 5'd8,
    e_stall_mul_busy           = 5'd9,
    e_stall_div_busy           = 5'd10,
    e_stall_mem_ordering       = 5'd11,
    e_stall_fence              = 5'd12,
    e_stall_csr_serialize      = 5'd13,
    e_stall_interrupt          = 5'd14,
    e_stall_exception          = 5'd15,
    e_stall_replay             = 5'd16,
    e_stall_struct_hazard      = 5'd17,
    e_stall_data_hazard_int    = 5'd18,
    e_stall_data_hazard_fp     = 5'd19,
    e_stall_cmd_queue_full     = 5'd20,
    e_stall_writeback_conflict = 5'd21,
    e_stall_debug_mode         = 5'd22,
    e_stall_wfi                = 5'd23
  } bp_stall_reason_e;

  typedef struct packed {
    logic [stall_idx_width_gp-1:0]   index;
    logic [stall_count_width_gp-1:0] count;
  } bp_stall_beat_s;

  // Never returns 0, so a width derived from it is always legal.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_stall_prof_drain.sv
// Shadow bank plus e_idle/e_drain FSM streaming {index, count} beats.
// BP_STALL_PROF_SKIP_ZERO_EN: skip zero-count reason entries (instret always sent).
module bp_stall_prof_drain
  import bp_be_pkg::*;
#(
  parameter int num_reasons_p   = stall_reason_num_gp,
  parameter int counter_width_p = 32,
  parameter int idx_width_lp    = safe_clog2(num_reasons_p + 1)
)
(
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          i_load,
  input  logic [num_reasons_p:0][counter_width_p-1:0]   i_bank,
  input  logic                                          i_ready,
  output logic                                          o_idle,
  output logic [idx_width_lp+counter_width_p-1:0]       o_data,
  output logic                                          o_v,
  output logic                                          o_last
);

  localparam logic [0:0] e_idle  = 1'b0;
  localparam logic [0:0] e_drain = 1'b1;

  logic [0:0]                                 r_state;
  logic [idx_width_lp-1:0]                    r_ptr;
  logic [num_reasons_p:0][counter_width_p-1:0] r_shadow;
  logic                                       w_at_last;
  logic                                       w_present;
  logic                                       w_advance;

  assign w_at_last = (r_ptr == idx_width_lp'(num_reasons_p));

`ifdef BP_STALL_PROF_SKIP_ZERO_EN
  // Zero reason entries occupy one pointer step but never present a beat.
  assign w_present = w_at_last | (r_shadow[r_ptr] != '0);
`else
  assign w_present = 1'b1;
`endif

  assign o_idle    = (r_state == e_idle);
  assign o_v       = (r_state == e_drain) & w_present;
  assign o_last    = o_v & w_at_last;
  assign o_data    = o_v ? {r_ptr, r_shadow[r_ptr]} : '0;
  assign w_advance = (r_state == e_drain) & (~w_present | i_ready);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= e_idle;
      r_ptr    <= '0;
      r_shadow <= '0;
    end else if (i_load) begin
      r_state  <= e_drain;
      r_ptr    <= '0;
      r_shadow <= i_bank;
    end else if (w_advance) begin
      if (w_at_last) begin
        r_state <= e_idle;
        r_ptr   <= '0;
      end else begin
        r_ptr <= r_ptr + idx_width_lp'(1);
      end
    end
  end

endmodule

// File: rtl/bp_stall_prof_sampler.sv
// Stall-reason accounting: live counter bank, sample-period timer, overrun flag.
// Optional zero-entry skipping in the drain via BP_STALL_PROF_SKIP_ZERO_EN.
module bp_stall_prof_sampler
  import bp_be_pkg::*;
#(
  parameter int num_reasons_p   = stall_reason_num_gp,
  parameter int counter_width_p = 32,
  parameter int sample_period_p = 1024,
  parameter int idx_width_lp    = safe_clog2(num_reasons_p + 1)
)
(
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    freeze_i,
  input  logic                                    enable_i,
  input  logic                                    instret_i,
  input  logic [idx_width_lp-1:0]                 stall_reason_i,
  output logic [idx_width_lp+counter_width_p-1:0] data_o,
  output logic                                    v_o,
  input  logic                                    ready_i,
  output logic                                    last_o,
  output logic                                    overrun_o
);

  localparam int period_width_lp = safe_clog2(sample_period_p);

  logic [num_reasons_p:0][counter_width_p-1:0] r_live;
  logic [num_reasons_p:0][counter_width_p-1:0] w_live_next;
  logic [period_width_lp-1:0]                 r_period;
  logic                                       r_overrun;
  logic                                       w_active;
  logic                                       w_snapshot_req;
  logic                                       w_drain_idle;
  logic                                       w_take;
  logic [idx_width_lp-1:0]                    w_slot;

  assign w_active       = enable_i & ~freeze_i;
  assign w_snapshot_req = w_active & (r_period == period_width_lp'(sample_period_p - 1));
  assign w_take         = w_snapshot_req & w_drain_idle;
  assign overrun_o      = r_overrun;

  always_comb begin
    if (instret_i) begin
      w_slot = idx_width_lp'(num_reasons_p);
    end else if (stall_reason_i >= idx_width_lp'(num_reasons_p)) begin
      w_slot = idx_width_lp'(int'(e_stall_unknown));
    end else begin
      w_slot = stall_reason_i;
    end
  end

  // The snapshot copies this bank so the terminal cycle's event is included.
  always_comb begin
    w_live_next = r_live;
    if (w_active && (r_live[w_slot] != '1)) begin
      w_live_next[w_slot] = r_live[w_slot] + counter_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_live <= '0;
    end else if (w_take) begin
      r_live <= '0;
    end else begin
      r_live <= w_live_next;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_period <= '0;
    end else if (w_active) begin
      r_period <= w_snapshot_req ? '0 : r_period + period_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_overrun <= 1'b0;
    end else if (w_snapshot_req && !w_drain_idle) begin
      r_overrun <= 1'b1;
    end
  end

  bp_stall_prof_drain #(
    .num_reasons_p   (num_reasons_p),
    .counter_width_p (counter_width_p),
    .idx_width_lp    (idx_width_lp)
  ) u_drain (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_load  (w_take),
    .i_bank  (w_live_next),
    .i_ready (ready_i),
    .o_idle  (w_drain_idle),
    .o_data  (data_o),
    .o_v     (v_o),
    .o_last  (last_o)
  );

endmodule

// File: tb/tb_bp_stall_prof_sampler.sv
// Self-checking bench for bp_stall_prof_sampler: directed phases plus random
// traffic compared against a queue-based model of the snapshot stream.
module tb_bp_stall_prof_sampler;

  localparam int NR   = 24;
  localparam int CW   = 6;
  localparam int SP   = 32;
  localparam int IW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              freeze_i;
  logic              enable_i;
  logic              instret_i;
  logic [IW-1:0]     stall_reason_i;
  logic [IW+CW-1:0]  data_o;
  logic              v_o;
  logic              ready_i;
  logic              last_o;
  logic              overrun_o;

  bp_stall_prof_sampler #(
    .num_reasons_p   (NR),
    .counter_width_p (CW),
    .sample_period_p (SP)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .freeze_i       (freeze_i),
    .enable_i       (enable_i),
    .instret_i      (instret_i),
    .stall_reason_i (stall_reason_i),
    .data_o         (data_o),
    .v_o            (v_o),
    .ready_i        (ready_i),
    .last_o         (last_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Each slot is one drain cycle: a beat, or a skipped zero entry (bubble).
  typedef struct {
    bit bubble;
    int idx;
    int cnt;
  } slot_t;

  int     liveCnt [NR+1];
  int     periodCnt;
  bit     overrunExp;
  slot_t  drainQ [$];
  int     modelBeats;
  int     dutBeats;
  int     checks;
  int     errors;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i <= NR; i++) liveCnt[i] = 0;
    periodCnt  = 0;
    overrunExp = 1'b0;
    drainQ.delete();
  endtask

  task automatic modelStep(input bit en, input bit fr, input bit ir, input int rs, input bit rd);
    bit    wasIdle;
    bit    req;
    int    slot;
    slot_t s;
    wasIdle = (drainQ.size() == 0);
    if (!wasIdle) begin
      if (drainQ[0].bubble) begin
        void'(drainQ.pop_front());
      end else if (rd) begin
        void'(drainQ.pop_front());
        modelBeats++;
      end
    end
    if (en && !fr) begin
      slot = ir ? NR : ((rs >= NR) ? 0 : rs);
      if (liveCnt[slot] < MAXC) liveCnt[slot]++;
      req       = (periodCnt == SP - 1);
      periodCnt = req ? 0 : periodCnt + 1;
      if (req && wasIdle) begin
        for (int i = 0; i <= NR; i++) begin
          s.idx = i;
          s.cnt = liveCnt[i];
`ifdef BP_STALL_PROF_SKIP_ZERO_EN
          s.bubble = (i < NR) && (liveCnt[i] == 0);
`else
          s.bubble = 1'b0;
`endif
          drainQ.push_back(s);
          liveCnt[i] = 0;
        end
      end else if (req) begin
        overrunExp = 1'b1;
      end
    end
  endtask

  task automatic checkCycle();
    bit expV;
    expV = (drainQ.size() > 0) && !drainQ[0].bubble;
    checkOutput("v_o", v_o, expV);
    if (expV) begin
      checkOutput("beat_index", data_o[IW+CW-1:CW], drainQ[0].idx);
      checkOutput("beat_count", data_o[CW-1:0], drainQ[0].cnt);
      checkOutput("last_o", last_o, (drainQ[0].idx == NR) ? 1 : 0);
    end else begin
      checkOutput("last_o_idle", last_o, 0);
    end
    checkOutput("overrun_o", overrun_o, overrunExp);
  endtask

  // Called just after a falling edge: drive, clock, update model, check.
  task automatic applyStimulus(input bit en, input bit fr, input bit ir, input int rs, input bit rd);
    enable_i       = en;
    freeze_i       = fr;
    instret_i      = ir;
    stall_reason_i = IW'(rs);
    ready_i        = rd;
    if (v_o && rd) dutBeats++;
    @(posedge clk_i);
    modelStep(en, fr, ir, rs, rd);
    @(negedge clk_i);
    checkCycle();
  endtask

  task automatic randomCycle(input int readyPct);
    applyStimulus(($urandom % 8) != 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
                  int'($urandom % 32), int'($urandom % 100) < readyPct);
  endtask

  task automatic drainIdle(input int cycles, input int stallFrom, input int stallLen);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(1'b0, 1'b0, $urandom % 2, int'($urandom % 32),
                    !(c >= stallFrom && c < stallFrom + stallLen));
    end
  endtask

  initial begin
    int startDut;
    int startModel;
    checks     = 0;
    errors     = 0;
    modelBeats = 0;
    dutBeats   = 0;
    reset_i        = 1'b1;
    freeze_i       = 1'b0;
    enable_i       = 1'b0;
    instret_i      = 1'b0;
    stall_reason_i = '0;
    ready_i        = 1'b0;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_v_o", v_o, 0);
    checkOutput("reset_last_o", last_o, 0);
    checkOutput("reset_overrun_o", overrun_o, 0);
    checkOutput("reset_data_o", data_o, 0);
    reset_i = 1'b0;

    $display("[TB] basic count");
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b1);
    for (int c = 0; c < 22; c++) applyStimulus(1'b1, 1'b0, 1'b0, 6, 1'b1);
    drainIdle(NR + 2, 0, 0);

    $display("[TB] backpressure");
    for (int c = 0; c < SP; c++) applyStimulus(1'b1, 1'b0, ($urandom % 3) == 0, int'($urandom % NR), 1'b1);
    startDut   = dutBeats;
    startModel = modelBeats;
    drainIdle(NR + 8, 8, 5);
    checkOutput("beat_total", dutBeats - startDut, modelBeats - startModel);

    $display("[TB] overrun and saturation");
    for (int c = 0; c < SP; c++) applyStimulus(1'b1, 1'b0, 1'b0, 3, 1'b1);
    for (int c = 0; c < 40; c++) applyStimulus(1'b1, 1'b0, 1'b0, 3, 1'b0);
    drainIdle(NR + 2, 0, 0);
    for (int c = 0; c < SP - 8; c++) applyStimulus(1'b1, 1'b0, 1'b0, 3, 1'b1);
    drainIdle(NR + 2, 0, 0);

    $display("[TB] freeze");
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b1, $urandom % 2, int'($urandom % 32), 1'b1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) randomCycle(75);

    $display("[TB] reset mid-drain");
    for (int c = 0; c < 200 && drainQ.size() != 0; c++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int c = 0; c < 2 * SP && drainQ.size() == 0; c++)
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b1);
    startDut = dutBeats;
    for (int c = 0; c < 4 * NR && (dutBeats - startDut) < 7; c++)
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("beats_before_reset", dutBeats - startDut, 7);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midreset_v_o", v_o, 0);
    checkOutput("midreset_last_o", last_o, 0);
    checkOutput("midreset_overrun_o", overrun_o, 0);
    checkOutput("midreset_data_o", data_o, 0);
    modelReset();
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 200; c++) randomCycle(90);
    drainIdle(4 * NR, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_stall_prof_sampler.md
# bp_stall_prof_sampler

Synthesizable stall-reason accounting controller for the BlackParrot back end. Each cycle it classifies the retiring slot as either an instruction retire or one encoded stall reason and accumulates it into a live counter bank. Every sample period it snapshots the bank into a shadow bank, clears the live bank and drains the shadow bank over a valid/ready stream. The block sits beside the commit stage and feeds an on-chip trace or debug sink in place of simulation-only file dumps.

## Interface
Parameters:
- num_reasons_p, 24: number of stall reasons; reason codes are 0..num_reasons_p-1.
- counter_width_p, 32: width of each count.
- sample_period_p, 1024: cycles per sample period; must be ≥ num_reasons_p+2.
- idx_width_lp, `BSG_SAFE_CLOG2(num_reasons_p+1)`: width of the entry index.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- freeze_i  in  1  core frozen; no counting and no period advance.
- enable_i  in  1  profiling enabled; low holds the live counters and the period counter.
- instret_i  in  1  an instruction retired this cycle.
- stall_reason_i  in  idx_width_lp  encoded stall reason; sampled only when instret_i=0.
- data_o  out  idx_width_lp+counter_width_p  drain beat, {index, count}.
- v_o  out  1  drain beat valid.
- ready_i  in  1  sink accepts the beat.
- last_o  out  1  current beat is the final beat of the snapshot.
- overrun_o  out  1  sticky; a snapshot was dropped.

## Operation
- **Accounting.** Active when enable_i=1 and freeze_i=0.
  - instret_i=1: increment entry num_reasons_p (instret).
  - instret_i=0: increment entry stall_reason_i.
  - An out-of-range reason code (≥ num_reasons_p) counts as reason 0 ("unknown").
- **Saturation.** Counters saturate at all-ones and never wrap.
- **Period counter.** Counts 0..sample_period_p-1 on active cycles. At terminal count it wraps to 0 and raises snapshot_req.
- **Snapshot.** Taken on snapshot_req when the drain FSM is in e_idle.
  - The shadow bank loads the live bank, including that cycle's increment.
  - The live bank clears to 0.
  - The drain FSM moves to e_drain.
- **Overrun.** snapshot_req while in e_drain sets overrun_o. The snapshot is dropped, the live bank is not cleared and keeps accumulating, and the drain continues unaffected.
- **Drain FSM.** States e_idle and e_drain.
  - In e_drain the pointer starts at 0. Each beat presents {ptr, shadow[ptr]}.
  - The pointer advances only on v_o & ready_i.
  - Order: reasons 0..num_reasons_p-1, then instret at index num_reasons_p with last_o=1.
  - A handshake on the last beat returns the FSM to e_idle.
- **Stability.** data_o, v_o and last_o stay stable while v_o=1 and ready_i=0.
- **enable_i and freeze_i** do not pause the drain.

## Timing
- Reset values:
  - all counters, shadow bank and period counter are 0;
  - v_o=0, last_o=0, overrun_o=0, data_o=0;
  - drain FSM in e_idle.
- Reset asserted mid-drain clears all state immediately, and v_o drops asynchronously.
- Snapshot latency: v_o rises the cycle after the terminal-count edge.
- Throughput: one beat per cycle with ready_i held high. A full drain takes num_reasons_p+1 cycles.
- A retire or stall event appears in the snapshot of the period in which it is counted.
- overrun_o clears only on reset.

## Configuration
- Macro: BP_STALL_PROF_SKIP_ZERO_EN.
- **Defined:**
  - The drain pointer skips zero-count reason entries at one entry per cycle, presenting no beat for them.
  - The instret entry is always emitted and carries last_o=1, even when its count is 0.
  - Skip cycles add to drain latency.
- **Undefined:** every entry is emitted, num_reasons_p+1 beats per snapshot.

## Structure
- bp_be_pkg holds:
  - the shared stall-reason enum (codes 0..23, 0 = unknown);
  - the reason-count constant;
  - the packed drain-beat struct {index, count}.
- Sub-module bp_stall_prof_drain contains the shadow bank, the drain pointer and the e_idle/e_drain FSM.
- The top level holds the live bank, the period counter and the overrun logic.

## Test plan
- **Basic count.** sample_period_p=32; 10 retires, then 22 cycles of reason 6; ready_i=1 → beats give index 6 = 22 and index 24 = 10 with last_o=1; all other entries 0.
- **Backpressure.** Hold ready_i=0 for 5 cycles mid-drain → data_o stable; no beat lost or duplicated; 25 total beats.
- **Overrun.** ready_i=0 for 40 cycles with period 32 → overrun_o=1 at the second terminal count; the next snapshot covers 64 cycles of counts.
- **Saturation and freeze.**
  - counter_width_p=4 with 20 stalls of reason 3 → count 15.
  - freeze_i=1 for 8 cycles → no counts and no period advance.
- **Reset mid-drain.** Assert reset_i during beat 7 → v_o=0 immediately; after release, counting restarts from 0.
- **BP_STALL_PROF_SKIP_ZERO_EN.** Only reasons 2 and 9 nonzero → exactly 3 beats, indices 2, 9, 24.
